// File: rtl/am2901_if.sv
`default_nettype none
// ============================================================================
//  Module   : am2901_if
//  Brief    : Data, microcode and status bundle of one Am2901 slice.
//  Revision : 1.0 - initial release
// ============================================================================
interface am2901_if;
   logic [3:0] din;
   logic [3:0] a;
   logic [3:0] b;
   logic [2:0] src;
   logic [2:0] op;
   logic [2:0] dest;
   logic       cin;
   logic [3:0] yout;
   logic       cout;
   logic       f0;
   logic       f3;
   logic       ovr;

   modport master (
      output din, a, b, src, op, dest, cin,
      input  yout, cout, f0, f3, ovr
   );

   modport slave (
      input  din, a, b, src, op, dest, cin,
      output yout, cout, f0, f3, ovr
   );
endinterface
`default_nettype wire

// File: rtl/am2901.sv
`default_nettype none
// ============================================================================
//  Module   : am2901
//  Brief    : 4-bit ALU/register slice (16x4 register file, Q, ALU, shifter).
//  Revision : 1.0 - initial release
// ============================================================================
module am2901 (
   input  logic      clock,
   input  logic      reset,
   am2901_if.slave   bus
);
   localparam logic [2:0] c_SRC_AQ = 3'd0, c_SRC_AB = 3'd1, c_SRC_ZQ = 3'd2,
                          c_SRC_ZB = 3'd3, c_SRC_ZA = 3'd4, c_SRC_DA = 3'd5,
                          c_SRC_DQ = 3'd6, c_SRC_DZ = 3'd7;
   localparam logic [2:0] c_OP_ADD = 3'd0, c_OP_SUBR = 3'd1, c_OP_SUBS = 3'd2,
                          c_OP_OR  = 3'd3, c_OP_AND  = 3'd4, c_OP_NOTRS = 3'd5,
                          c_OP_EXOR = 3'd6, c_OP_EXNOR = 3'd7;
   localparam logic [2:0] c_DST_QREG = 3'd0, c_DST_NOP = 3'd1, c_DST_RAMA = 3'd2,
                          c_DST_RAMF = 3'd3, c_DST_RAMQD = 3'd4, c_DST_RAMD = 3'd5,
                          c_DST_RAMQU = 3'd6, c_DST_RAMU = 3'd7;

   logic [3:0] r_ram [16];
   logic [3:0] r_q;

   logic [3:0] w_a, w_b, w_r, w_s, w_x, w_y, w_f;
   logic [4:0] w_sum;
   logic       w_arith, w_c3;

   assign w_a = r_ram[bus.a];
   assign w_b = r_ram[bus.b];

   always_comb begin
      w_r = 4'h0;
      w_s = 4'h0;
      case (bus.src)
         c_SRC_AQ: begin w_r = w_a;     w_s = r_q; end
         c_SRC_AB: begin w_r = w_a;     w_s = w_b; end
         c_SRC_ZQ: begin w_r = 4'h0;    w_s = r_q; end
         c_SRC_ZB: begin w_r = 4'h0;    w_s = w_b; end
         c_SRC_ZA: begin w_r = 4'h0;    w_s = w_a; end
         c_SRC_DA: begin w_r = bus.din; w_s = w_a; end
         c_SRC_DQ: begin w_r = bus.din; w_s = r_q; end
         c_SRC_DZ: begin w_r = bus.din; w_s = 4'h0; end
         default:  begin w_r = 4'h0;    w_s = 4'h0; end
      endcase
   end

   // Subtraction is done by inverting one adder operand; cin supplies the +1.
   assign w_x     = (bus.op == c_OP_SUBR) ? ~w_r : w_r;
   assign w_y     = (bus.op == c_OP_SUBS) ? ~w_s : w_s;
   assign w_sum   = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, bus.cin};
   assign w_c3    = w_x[3] ^ w_y[3] ^ w_sum[3];
   assign w_arith = (bus.op == c_OP_ADD) || (bus.op == c_OP_SUBR) || (bus.op == c_OP_SUBS);

   always_comb begin
      w_f = 4'h0;
      case (bus.op)
         c_OP_ADD, c_OP_SUBR, c_OP_SUBS: w_f = w_sum[3:0];
         c_OP_OR:    w_f = w_r | w_s;
         c_OP_AND:   w_f = w_r & w_s;
         c_OP_NOTRS: w_f = ~w_r & w_s;
         c_OP_EXOR:  w_f = w_r ^ w_s;
         c_OP_EXNOR: w_f = ~(w_r ^ w_s);
         default:    w_f = 4'h0;
      endcase
   end

   assign bus.yout = (bus.dest == c_DST_RAMA) ? w_a : w_f;
   assign bus.cout = w_arith & w_sum[4];
   assign bus.ovr  = w_arith & (w_c3 ^ w_sum[4]);
   assign bus.f0   = (w_f == 4'h0);
   assign bus.f3   = w_f[3];

   // Shift-in bits at the ends of the RAM and Q shifters are tied to zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) r_ram[i] <= 4'h0;
         r_q <= 4'h0;
      end else begin
         case (bus.dest)
            c_DST_QREG:  r_q <= w_f;
            c_DST_NOP:   ;
            c_DST_RAMA,
            c_DST_RAMF:  r_ram[bus.b] <= w_f;
            c_DST_RAMQD: begin
               r_ram[bus.b] <= {1'b0, w_f[3:1]};
               r_q          <= {1'b0, r_q[3:1]};
            end
            c_DST_RAMD:  r_ram[bus.b] <= {1'b0, w_f[3:1]};
            c_DST_RAMQU: begin
               r_ram[bus.b] <= {w_f[2:0], 1'b0};
               r_q          <= {r_q[2:0], 1'b0};
            end
            c_DST_RAMU:  r_ram[bus.b] <= {w_f[2:0], 1'b0};
            default:     ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_am2901.sv
`default_nettype none
// ============================================================================
//  Module   : tb_am2901
//  Brief    : Directed self-checking bench for am2901, incl. a two-slice chain.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_am2901;
   logic clock;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   am2901_if bus0 ();
   am2901_if bus1 ();

   am2901 alu0 (.clock(clock), .reset(reset), .bus(bus0));
   am2901 alu1 (.clock(clock), .reset(reset), .bus(bus1));

   assign bus1.cin = bus0.cout;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive0(input logic [3:0] din, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] src, input logic [2:0] op,
                         input logic [2:0] dest, input logic cin);
      bus0.din = din; bus0.a = a; bus0.b = b;
      bus0.src = src; bus0.op = op; bus0.dest = dest; bus0.cin = cin;
      #1;
   endtask

   task automatic drive1(input logic [3:0] din, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] src, input logic [2:0] op, input logic [2:0] dest);
      bus1.din = din; bus1.a = a; bus1.b = b;
      bus1.src = src; bus1.op = op; bus1.dest = dest;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Write value v into RAM[b] of slice 0 (D + 0, RAMF).
   task automatic load0(input logic [3:0] b, input logic [3:0] v);
      drive0(v, 4'h0, b, 3'd7, 3'd0, 3'd3, 1'b0);
      tick();
   endtask

   initial begin
      reset = 1'b1;
      drive1(4'h0, 4'h0, 4'h0, 3'd0, 3'd0, 3'd1);
      drive0(4'h0, 4'h0, 4'h0, 3'd0, 3'd0, 3'd1, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state: OR of two cleared words
      drive0(4'h0, 4'h5, 4'h9, 3'd1, 3'd3, 3'd1, 1'b0);
      check("rst_yout", bus0.yout, 8'h0);
      check("rst_f0",   bus0.f0,   8'h1);
      check("rst_cout", bus0.cout, 8'h0);
      check("rst_ovr",  bus0.ovr,  8'h0);

      // D + 0 + cin into RAM[2]
      drive0(4'h6, 4'h0, 4'h2, 3'd7, 3'd0, 3'd3, 1'b1);
      check("dplus1_y", bus0.yout, 8'h7);
      tick();
      drive0(4'h0, 4'h0, 4'h2, 3'd3, 3'd0, 3'd1, 1'b0);
      check("ram2_y",  bus0.yout, 8'h7);
      check("ram2_f0", bus0.f0,   8'h0);

      // Signed overflow: 1 + 7
      load0(4'h1, 4'h7);
      drive0(4'h1, 4'h1, 4'h0, 3'd5, 3'd0, 3'd1, 1'b0);
      check("ovf_y",    bus0.yout, 8'h8);
      check("ovf_f3",   bus0.f3,   8'h1);
      check("ovf_ovr",  bus0.ovr,  8'h1);
      check("ovf_cout", bus0.cout, 8'h0);

      // Carry out with zero result: F + 1
      load0(4'h3, 4'hF);
      load0(4'h4, 4'h1);
      drive0(4'h0, 4'h3, 4'h4, 3'd1, 3'd0, 3'd1, 1'b0);
      check("wrap_y",    bus0.yout, 8'h0);
      check("wrap_cout", bus0.cout, 8'h1);
      check("wrap_f0",   bus0.f0,   8'h1);
      check("wrap_ovr",  bus0.ovr,  8'h0);

      // Q load, then down shift, then up shift
      drive0(4'hA, 4'h0, 4'h0, 3'd7, 3'd0, 3'd0, 1'b0);
      tick();
      drive0(4'h0, 4'h0, 4'h6, 3'd2, 3'd0, 3'd1, 1'b0);
      check("q_load", bus0.yout, 8'hA);
      drive0(4'h0, 4'h0, 4'h6, 3'd2, 3'd0, 3'd4, 1'b0);
      check("qd_y", bus0.yout, 8'hA);
      tick();
      drive0(4'h0, 4'h0, 4'h6, 3'd2, 3'd0, 3'd1, 1'b0);
      check("qd_q", bus0.yout, 8'h5);
      drive0(4'h0, 4'h0, 4'h6, 3'd3, 3'd0, 3'd1, 1'b0);
      check("qd_ram6", bus0.yout, 8'h5);
      drive0(4'h0, 4'h0, 4'h6, 3'd2, 3'd0, 3'd6, 1'b0);
      tick();
      drive0(4'h0, 4'h0, 4'h6, 3'd2, 3'd0, 3'd1, 1'b0);
      check("qu_q", bus0.yout, 8'hA);
      drive0(4'h0, 4'h0, 4'h6, 3'd3, 3'd0, 3'd1, 1'b0);
      check("qu_ram6", bus0.yout, 8'hA);

      // RAMA output, then the written OR result
      load0(4'h0, 4'h3);
      load0(4'h1, 4'h9);
      drive0(4'h0, 4'h0, 4'h1, 3'd1, 3'd3, 3'd2, 1'b0);
      check("rama_y", bus0.yout, 8'h3);
      tick();
      drive0(4'h0, 4'h0, 4'h1, 3'd3, 3'd0, 3'd1, 1'b0);
      check("rama_ram1", bus0.yout, 8'hB);

      // Remaining functions with R=A=3, S=B=B
      drive0(4'h0, 4'h0, 4'h1, 3'd1, 3'd1, 3'd1, 1'b1);
      check("subr_y",    bus0.yout, 8'h8);
      check("subr_cout", bus0.cout, 8'h1);
      check("subr_ovr",  bus0.ovr,  8'h0);
      drive0(4'h0, 4'h0, 4'h1, 3'd1, 3'd2, 3'd1, 1'b1);
      check("subs_y",    bus0.yout, 8'h8);
      check("subs_cout", bus0.cout, 8'h0);
      check("subs_ovr",  bus0.ovr,  8'h1);
      drive0(4'h0, 4'h0, 4'h1, 3'd1, 3'd4, 3'd1, 1'b0);
      check("and_y", bus0.yout, 8'h3);
      drive0(4'h0, 4'h0, 4'h1, 3'd1, 3'd5, 3'd1, 1'b0);
      check("notrs_y", bus0.yout, 8'h8);
      drive0(4'h0, 4'h0, 4'h1, 3'd1, 3'd6, 3'd1, 1'b0);
      check("exor_y", bus0.yout, 8'h8);
      drive0(4'h0, 4'h0, 4'h1, 3'd1, 3'd7, 3'd1, 1'b1);
      check("exnor_y",    bus0.yout, 8'h7);
      check("exnor_cout", bus0.cout, 8'h0);
      check("exnor_ovr",  bus0.ovr,  8'h0);

      // Two-slice chain: 0x0F + 1
      drive1(4'h0, 4'h0, 4'h5, 3'd7, 3'd0, 3'd3);
      drive0(4'hF, 4'h0, 4'h5, 3'd7, 3'd0, 3'd3, 1'b0);
      tick();
      drive1(4'h0, 4'h5, 4'h0, 3'd5, 3'd0, 3'd1);
      drive0(4'h1, 4'h5, 4'h0, 3'd5, 3'd0, 3'd1, 1'b0);
      check("chain_y",    {bus1.yout, bus0.yout}, 8'h10);
      check("chain_cout", bus0.cout, 8'h1);

      // Asynchronous reset between edges
      reset = 1'b1;
      drive0(4'h0, 4'h0, 4'h1, 3'd3, 3'd0, 3'd1, 1'b0);
      check("arst_ram1", bus0.yout, 8'h0);
      drive0(4'h0, 4'h0, 4'h0, 3'd2, 3'd0, 3'd1, 1'b0);
      check("arst_q", bus0.yout, 8'h0);
      drive0(4'h0, 4'h6, 4'h0, 3'd4, 3'd0, 3'd1, 1'b0);
      check("arst_ram6", bus0.yout, 8'h0);
      reset = 1'b0;

      // First edge after release writes normally
      load0(4'h2, 4'h5);
      drive0(4'h0, 4'h0, 4'h2, 3'd3, 3'd0, 3'd1, 1'b0);
      check("post_rst_wr", bus0.yout, 8'h5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
